// File: rtl/port_io_pkg.sv
// port_io_pkg -- shared constants for the PORT_IN register map.
// The same offsets are mirrored by the processor software map, so any change
// here must be reflected there as well.
package port_io_pkg;

  // Default board population.
  localparam int unsigned N_SW_DEFAULT  = 16;
  localparam int unsigned N_BTN_DEFAULT = 5;

  // PORT_IN_A field offsets for the default population.
  localparam int unsigned SW_LSB  = 0;
  localparam int unsigned BTN_LSB = SW_LSB + N_SW_DEFAULT;

  // Width of the optional press counter presented on PORT_IN_C.
  localparam int unsigned PRESS_CNT_W = 16;

  // Bits needed to hold 0..cycles without wrapping.
  function automatic int unsigned dbnc_cnt_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

  // Button field offset for a non-default switch count.
  function automatic int unsigned btn_lsb_for(input int unsigned n_sw);
    return SW_LSB + n_sw;
  endfunction

endpackage : port_io_pkg

// File: rtl/debounce_bit.sv
// debounce_bit -- two-flop synchronizer followed by a stability-window
// debouncer for a single asynchronous input bit.
// o_stable changes only after the synchronized level has differed from the
// current stable level on DEBOUNCE_CYCLES consecutive clock edges.
module debounce_bit
  import port_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_stable
);

  localparam int unsigned     CNT_W    = dbnc_cnt_width(DEBOUNCE_CYCLES);
  // Count value on which the next mismatching edge completes the window.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;

  // Two-flop synchronizer: nothing else ever looks at i_raw.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, exactly like the hardware chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Stability window: count edges of disagreement, adopt the new level on the
  // edge the count would reach DEBOUNCE_CYCLES. Any agreement restarts it, so
  // the counter tops out at DEBOUNCE_CYCLES-1 and can never wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else if (r_sync2 == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_stable <= r_sync2;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_stable = r_stable;

endmodule : debounce_bit

// File: rtl/port_in_debounce.sv
// port_in_debounce -- debounced switch/button input port.
//   PORT_IN_A : registered debounced levels {buttons, switches}, zero-extended.
//   PORT_IN_B : sticky button-press flags, cleared by evt_clr/evt_clr_mask.
//   PORT_IN_C : button press counter when PORT_IN_PRESS_COUNT_EN is defined,
//               otherwise constant zero.
// Rise detection compares each bit's debouncer output with the PORT_IN_A
// register, so a press sets its flag on the very edge PORT_IN_A shows it.
// Assumes WIDTH >= N_SW + N_BTN, WIDTH > N_BTN and WIDTH >= 16.
module port_in_debounce
  import port_io_pkg::*;
#(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned N_SW            = N_SW_DEFAULT,
  parameter int unsigned N_BTN           = N_BTN_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SW-1:0]  sw_raw,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             evt_clr,
  input  logic [WIDTH-1:0] evt_clr_mask,
  output logic [WIDTH-1:0] PORT_IN_A,
  output logic [WIDTH-1:0] PORT_IN_B,
  output logic [WIDTH-1:0] PORT_IN_C
);

  localparam int unsigned N_IN     = N_SW + N_BTN;
  localparam int unsigned BTN_OFFS = btn_lsb_for(N_SW);

  logic [N_IN-1:0]  w_raw;
  logic [N_IN-1:0]  w_stable;
  logic [N_BTN-1:0] w_btn_rise;
  logic [N_BTN-1:0] w_clr;
  logic             w_unused_mask_hi;

  logic [N_IN-1:0]  r_level;
  logic [N_BTN-1:0] r_press_flag;

  // Packed in PORT_IN_A order so bit i of w_stable lands on PORT_IN_A[i].
  assign w_raw = {btn_raw, sw_raw};

  // One synchronizer+debouncer per raw input.
  for (genvar gi = 0; gi < N_IN; gi++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce_bit (
      .clk     (clk),
      .reset   (reset),
      .i_raw   (w_raw[gi]),
      .o_stable(w_stable[gi])
    );
  end : g_bit

  // A press is a debounced button that is high now but not yet in PORT_IN_A.
  assign w_btn_rise = w_stable[BTN_OFFS +: N_BTN] & ~r_level[BTN_OFFS +: N_BTN];

  // Only the flag bits of the clear mask are meaningful.
  assign w_clr            = evt_clr ? evt_clr_mask[N_BTN-1:0] : '0;
  assign w_unused_mask_hi = ^evt_clr_mask[WIDTH-1:N_BTN];

  // Output registers: debounced levels and sticky flags; a set beats a clear
  // on the same bit, and reset beats everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_level      <= '0;
      r_press_flag <= '0;
    end else begin
      r_level      <= w_stable;
      r_press_flag <= (r_press_flag & ~w_clr) | w_btn_rise;
    end
  end

  assign PORT_IN_A = WIDTH'(r_level);
  assign PORT_IN_B = WIDTH'(r_press_flag);

`ifdef PORT_IN_PRESS_COUNT_EN
  logic [PRESS_CNT_W-1:0] r_press_cnt;

  // Press counter: each rising button counts once, wrapping naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_press_cnt <= '0;
    end else begin
      r_press_cnt <= r_press_cnt + PRESS_CNT_W'($countones(w_btn_rise));
    end
  end

  assign PORT_IN_C = WIDTH'(r_press_cnt);
`else
  assign PORT_IN_C = '0;
`endif

endmodule : port_in_debounce
